// File: rtl/cmp_pkg.sv
// Shared types for the serial compare arbiter: FSM state encoding and
// requester-index width.
package cmp_pkg;

  localparam int unsigned ReqIdxW = 1;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant from a request pair, priority
// pointer advances past the winner whenever the update strobe accepts a grant.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  // Requester favoured on a tie; 0 after reset.
  logic prio_q, prio_d;

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    prio_d = prio_q;
    if (upd_i && (gnt_o != 2'b00)) begin
      prio_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/serial_compare_arbiter.sv
// Two-requester unsigned comparator: arbitrates, captures operands, then scans
// bit pairs MSB first with early exit on the first difference.
module serial_compare_arbiter
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic             req1,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             owner,
  output logic             greater,
  output logic             less,
  output logic             equal
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q;
  logic [WIDTH-1:0]   x_q, y_q;
  logic [IdxW-1:0]    idx_q;
  logic [ReqIdxW-1:0] owner_q;
  logic               gnt0_q, gnt1_q, busy_q, done_q;
  logic               greater_q, less_q, equal_q;
  logic [1:0]         arb_gnt;

  // Pointer only advances when a grant is actually taken from IDLE.
  rr_arb2 u_rr_arb2 (
    .clk_i (clk),
    .rst_i (reset),
    .req_i ({req1, req0}),
    .upd_i (state_q == StIdle),
    .gnt_o (arb_gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      idx_q     <= IdxW'(WIDTH - 1);
      owner_q   <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      greater_q <= 1'b0;
      less_q    <= 1'b0;
      equal_q   <= 1'b0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (arb_gnt != 2'b00) begin
            gnt0_q    <= arb_gnt[0];
            gnt1_q    <= arb_gnt[1];
            owner_q   <= arb_gnt[1];
            x_q       <= arb_gnt[1] ? x1 : x0;
            y_q       <= arb_gnt[1] ? y1 : y0;
            idx_q     <= IdxW'(WIDTH - 1);
            greater_q <= 1'b0;
            less_q    <= 1'b0;
            equal_q   <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= StScan;
          end
        end
        StScan: begin
          if (x_q[idx_q] != y_q[idx_q]) begin
            greater_q <= x_q[idx_q];
            less_q    <= y_q[idx_q];
            done_q    <= 1'b1;
            state_q   <= StDone;
          end else if (idx_q == '0) begin
            equal_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign owner   = owner_q;
  assign greater = greater_q;
  assign less    = less_q;
  assign equal   = equal_q;

endmodule

// File: tb/tb_serial_compare_arbiter.sv
// Directed self-checking bench for serial_compare_arbiter (WIDTH=8).
module tb_serial_compare_arbiter;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1;
  logic [WIDTH-1:0] x0, y0, x1, y1;
  logic             gnt0, gnt1, busy, done, owner, greater, less, equal;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  serial_compare_arbiter #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .x0      (x0),
    .y0      (y0),
    .req1    (req1),
    .x1      (x1),
    .y1      (y1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .busy    (busy),
    .done    (done),
    .owner   (owner),
    .greater (greater),
    .less    (less),
    .equal   (equal)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Returns granted index, or -1 if no grant within the budget.
  task automatic wait_gnt(output int who);
    who = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        who = gnt1 ? 1 : 0;
        return;
      end
    end
  endtask

  // Cycles from the grant cycle to done, or -1 if done never arrives.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic run_op(input string tag, input int who, input logic [7:0] x, input logic [7:0] y,
                        input int exp_lat, input logic [2:0] exp_gle, input bit change);
    int got, lat;
    if (who == 0) begin req0 = 1'b1; x0 = x; y0 = y; end
    else          begin req1 = 1'b1; x1 = x; y1 = y; end
    wait_gnt(got);
    check_eq({tag, "_gnt"}, got, who);
    check_eq({tag, "_busy_at_gnt"}, busy, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    if (change) begin x0 = 8'h00; y0 = 8'hFF; end
    wait_done(lat);
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_gle"}, {greater, less, equal}, exp_gle);
    check_eq({tag, "_owner"}, owner, who);
    check_eq({tag, "_busy_at_done"}, busy, 1);
    @(negedge clk);
    check_eq({tag, "_hold"}, {done, busy, greater, less, equal, owner},
             {2'b00, exp_gle, who[0]});
  endtask

  initial begin
    int got, lat, ng, bad_busy, both;
    int seq[4];
    bit prev_busy, saw_done;

    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_outs", {gnt0, gnt1, busy, done, owner, greater, less, equal}, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_no_req", {gnt0, gnt1, busy, done}, 0);

    run_op("gt_msb",  0, 8'hA5, 8'h25, 1, 3'b100, 1'b0);
    run_op("lt_lsb",  1, 8'h3C, 8'h3D, 8, 3'b010, 1'b0);
    run_op("eq",      0, 8'h7E, 8'h7E, 8, 3'b001, 1'b0);
    run_op("capture", 0, 8'h81, 8'h80, 8, 3'b100, 1'b1);

    // Both requesters held from reset: strict alternation starting with 0.
    reset = 1'b1;
    req0 = 1'b1; x0 = 8'h80; y0 = 8'h00;
    req1 = 1'b1; x1 = 8'h00; y1 = 8'h80;
    @(negedge clk);
    reset = 1'b0;
    ng = 0; bad_busy = 0; both = 0; prev_busy = busy;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (gnt0 && gnt1) both++;
      if (gnt0 || gnt1) begin
        if (prev_busy) bad_busy++;
        if (ng < 4) seq[ng] = gnt1 ? 1 : 0;
        ng++;
      end
      prev_busy = busy;
    end
    check_eq("alt_enough_grants", (ng >= 4), 1);
    for (int i = 0; i < 4; i++) begin
      if (i < ng) check_eq($sformatf("alt_grant%0d", i), seq[i], i % 2);
    end
    check_eq("alt_no_gnt_while_busy", bad_busy, 0);
    check_eq("alt_no_double_gnt", both, 0);
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the third SCAN cycle of 0x01 vs 0x00 aborts without done.
    req0 = 1'b1; x0 = 8'h01; y0 = 8'h00;
    wait_gnt(got);
    check_eq("abort_gnt", got, 0);
    saw_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      saw_done |= done;
    end
    reset = 1'b1;
    @(negedge clk);
    saw_done |= done;
    check_eq("abort_no_done", saw_done, 0);
    check_eq("abort_outs", {gnt0, gnt1, busy, done, owner, greater, less, equal}, 0);
    reset = 1'b0;
    wait_gnt(got);
    check_eq("abort_fresh_gnt", got, 0);
    req0 = 1'b0;
    wait_done(lat);
    check_eq("abort_fresh_latency", lat, 8);
    check_eq("abort_fresh_gle", {greater, less, equal}, 3'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
